// File: rtl/hazard_if.sv
// hazard_if: pipeline-to-hazard-unit signal bundle (register ids, hazard inputs, stall/flush/forward outputs)
interface hazard_if #(parameter int REG_ADDR_W = 5);
    logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic                  reg_write_m, reg_write_w, load_e, load_m, pc_src_e;
    logic [1:0]            forward_a_e, forward_b_e;
    logic                  stall_f, stall_d, stall_e, stall_m;
    logic                  flush_d, flush_e, flush_w, mem_busy;
    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        output reg_write_m, reg_write_w, load_e, load_m, pc_src_e,
        input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, flush_w, mem_busy
    );
    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        input  reg_write_m, reg_write_w, load_e, load_m, pc_src_e,
        output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, flush_w, mem_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding, load-use stall, branch flush and data-memory wait sequencing
module hazard_ctrl #(
    parameter int REG_ADDR_W      = 5,
    parameter int MEM_WAIT_CYCLES = 2
) (
    input logic     clk,
    input logic     reset_n,
    hazard_if.slave hz
);
    localparam int CW = MEM_WAIT_CYCLES > 0 ? $clog2(MEM_WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_WAIT_CYCLES > 0 ? MEM_WAIT_CYCLES - 1 : 0);
    localparam logic [1:0] RUN = 2'd0, WAIT = 2'd1, RELEASE = 2'd2;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    logic [1:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          trig, mem_stall, lw_stall;

    assign trig     = reset_n && hz.load_m && (MEM_WAIT_CYCLES > 0);
    assign lw_stall = hz.load_e && hz.rd_e != X0 && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);

    // forwarding selects: M stage result wins over W stage result, x0 never forwarded
    always_comb begin
        hz.forward_a_e = (hz.reg_write_m && hz.rd_m == hz.rs1_e && hz.rs1_e != X0) ? 2'b10 :
                         (hz.reg_write_w && hz.rd_w == hz.rs1_e && hz.rs1_e != X0) ? 2'b01 : 2'b00;
        hz.forward_b_e = (hz.reg_write_m && hz.rd_m == hz.rs2_e && hz.rs2_e != X0) ? 2'b10 :
                         (hz.reg_write_w && hz.rd_w == hz.rs2_e && hz.rs2_e != X0) ? 2'b01 : 2'b00;
    end

    // memory wait sequencing: stall on trigger and through WAIT, RELEASE lets the load leave M
    always_comb begin
        state_nx  = RUN;
        cnt_nx    = cnt;
        mem_stall = 1'b0;
        if (state == RUN && trig) begin
            mem_stall = 1'b1;
            cnt_nx    = CNT_INIT;
            state_nx  = (MEM_WAIT_CYCLES > 1) ? WAIT : RELEASE;
        end else if (state == WAIT) begin
            mem_stall = reset_n;
            cnt_nx    = cnt - CW'(1);
            state_nx  = (cnt == CW'(1)) ? RELEASE : WAIT;
        end
    end

    // state register, cleared asynchronously so a reset abandons any pending wait
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign hz.stall_f  = lw_stall | mem_stall;
    assign hz.stall_d  = lw_stall | mem_stall;
    assign hz.stall_e  = mem_stall;
    assign hz.stall_m  = mem_stall;
    assign hz.flush_w  = mem_stall;
    assign hz.flush_d  = hz.pc_src_e & ~mem_stall;
    assign hz.flush_e  = (lw_stall | hz.pc_src_e) & ~mem_stall;
    assign hz.mem_busy = mem_stall;
endmodule
